// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register width, slot record, drain states.
package hazard_scoreboard_pkg;

  localparam int REG_W = 3;
  localparam logic [REG_W-1:0] R7 = 3'd7;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> scoreboard bundle. master = decode stage, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int CNT_W = 16
);
  import hazard_scoreboard_pkg::*;

  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_we;
  logic             issue_ld;
  logic [REG_W-1:0] src1;
  logic [REG_W-1:0] src2;
  logic             src1_used;
  logic             src2_used;
  logic             pipe_en;
  logic             flush;
  logic             drain_req;
  logic             stall;
  logic [1:0]       hazard_src;
  logic             drain_done;
  logic             pipe_empty;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output issue_valid, issue_rd, issue_we, issue_ld, src1, src2, src1_used, src2_used,
           pipe_en, flush, drain_req,
    input  stall, hazard_src, drain_done, pipe_empty, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_ld, src1, src2, src1_used, src2_used,
           pipe_en, flush, drain_req,
    output stall, hazard_src, drain_done, pipe_empty, stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Compares one source register against every tracked slot. ELIG_MASK selects
// which slots may cause a hazard; LD_ONLY restricts hits to load producers.
module hazard_scoreboard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int               DEPTH     = 3,
  parameter logic [DEPTH-1:0] ELIG_MASK = '1,
  parameter bit               LD_ONLY   = 1'b0
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  slot_t            slots [DEPTH],
  output logic             hit
);

  // Any eligible, valid, writing slot whose destination equals this source.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ELIG_MASK[i] && slots[i].v && slots[i].we && (slots[i].rd == src) &&
          (!LD_ONLY || slots[i].ld))
        hit = 1'b1;
    end
    hit = hit & used;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes between decode and writeback, raises the
// decode stall on RAW hazards and sequences pipe draining.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter bit FWD_EN    = 1'b0,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);

  // With forwarding only a load still sitting in EX can hurt; without it every
  // slot counts, except WB when the register file writes before it reads.
  localparam logic [DEPTH-1:0] ELIG_MASK =
    FWD_EN    ? DEPTH'(1) :
    RF_BYPASS ? DEPTH'((1 << (DEPTH - 1)) - 1) :
                {DEPTH{1'b1}};

  slot_t            slots [DEPTH];
  drain_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hit1, hit2;
  logic             pipe_empty;
  logic [1:0]       hazard_src;
  logic             stall;

  hazard_scoreboard_match #(.DEPTH(DEPTH), .ELIG_MASK(ELIG_MASK), .LD_ONLY(FWD_EN)) u_match1 (
    .src(sb.src1), .used(sb.src1_used), .slots(slots), .hit(hit1)
  );

  hazard_scoreboard_match #(.DEPTH(DEPTH), .ELIG_MASK(ELIG_MASK), .LD_ONLY(FWD_EN)) u_match2 (
    .src(sb.src2), .used(sb.src2_used), .slots(slots), .hit(hit2)
  );

  assign hazard_src = {sb.issue_valid & hit2, sb.issue_valid & hit1};
  assign stall      = (|hazard_src) | (sb.issue_valid & (state_q != IDLE));

  // Pipe is empty when no slot holds a valid writer.
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots[i].v) pipe_empty = 1'b0;
    end
  end

  // Slot shift register: flush clears, pipe_en advances, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else if (sb.flush) begin
      for (int i = 0; i < DEPTH; i++) slots[i].v <= 1'b0;
    end else if (sb.pipe_en) begin
      for (int i = DEPTH - 1; i > 0; i--) slots[i] <= slots[i-1];
      slots[0] <= {sb.issue_valid & ~stall & sb.issue_we, sb.issue_rd, sb.issue_we, sb.issue_ld};
    end
  end

  // Saturating count of cycles lost to real hazards while the pipe advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if ((|hazard_src) && sb.pipe_en && (cnt_q != '1))
      cnt_q <= cnt_q + CNT_W'(1);
  end

  // Drain state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Drain next-state: wait for an empty pipe, hold DONE until the request drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sb.drain_req) state_d = DRAIN;
      DRAIN:   if (!sb.drain_req) state_d = IDLE;
               else if (pipe_empty) state_d = DONE;
      DONE:    if (!sb.drain_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sb.stall      = stall;
  assign sb.hazard_src = hazard_src;
  assign sb.drain_done = (state_q == DONE);
  assign sb.pipe_empty = pipe_empty;
  assign sb.stall_cnt  = cnt_q;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks in-flight register writes (rd, we_reg from the ALU destination decode) through the EX/MEM/WB pipeline.
- Stalls issue of a decoded instruction whose source registers are pending.
- Drains the pipe on request for HALT/SIIC/RTI sequencing.
- Sits between decode and the EX pipeline register; owns the decode-stage stall signal.

Parameters:
- DEPTH, 3, number of tracked stages after decode (slot 0 = EX, slot DEPTH-1 = WB).
- FWD_EN, 0: 0 = no forwarding, any pending match stalls; 1 = full forwarding, only load-use (load in slot 0) stalls.
- RF_BYPASS, 1: 1 = register file is write-before-read, so slot DEPTH-1 is excluded from matching.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rd  in  3  destination register from destination decode (7 for JAL/JALR).
- issue_we  in  1  instruction writes issue_rd.
- issue_ld  in  1  instruction is LD (result available only after MEM).
- src1 / src2  in  3 each  source register numbers.
- src1_used / src2_used  in  1 each  source is actually read.
- pipe_en  in  1  downstream stages advance this cycle (0 = global freeze).
- flush  in  1  squash all tracked slots (branch/jump redirect).
- drain_req  in  1  level request to empty the pipe.
- stall  out  1  hold PC and decode; insert bubble into EX.
- hazard_src  out  2  bit0 = src1 caused hazard, bit1 = src2.
- drain_done  out  1  pipe is empty while drain is held.
- pipe_empty  out  1  no valid slot.
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Slot i holds {v, rd, we, ld}.
- Match (src k, slot i) = srck_used & v[i] & we[i] & rd[i]==srck.
  - FWD_EN=0: slots 0..DEPTH-1 are eligible, minus DEPTH-1 when RF_BYPASS=1.
  - FWD_EN=1: only slot 0 with ld=1 is eligible.
- hazard_src[k] = issue_valid & (any eligible match for src k).
- stall = |hazard_src | (issue_valid & drain state != IDLE). Combinational; no added latency.
- Register 0 is an ordinary register in this ISA and is tracked like the others; there is no zero-register exception.
- Slot update on the clk rising edge, in priority order:
  - flush: every v <= 0.
  - else if pipe_en: slot i <= slot i-1; slot 0 <= {issue_valid & ~stall & issue_we, issue_rd, issue_we, issue_ld}. A stall inserts a bubble (v=0).
  - else: hold all slots.
- Instructions with we=0 (branches, ST used as no-write, NOP) enter slot 0 with v=0 and never match.
- pipe_empty = no v set.
- Drain FSM (registered):
  - IDLE -> DRAIN on drain_req.
  - DRAIN -> DONE when pipe_empty (flush counts toward this).
  - DONE -> IDLE when drain_req=0.
  - drain_req dropping while in DRAIN -> IDLE.
  - drain_done = (state==DONE). It is therefore one cycle after the pipe becomes empty.
- stall_cnt increments by 1 on each cycle where |hazard_src & pipe_en. Drain-only stalls are not counted. Saturates at all-ones; no wrap.
- A simultaneous flush and hazard: stall is still asserted that cycle, and flush wins for slot contents.
- Reset mid-operation: all slots invalid, state IDLE, stall_cnt=0, drain_done=0. Consequently stall=0 and pipe_empty=1 while in reset.

Decomposition:
- Shared package (isa_pkg): REG_W=3, R7=3'd7, slot struct {v, rd, we, ld}, drain state enum {IDLE, DRAIN, DONE}.
- One natural sub-module, scoreboard_match: combinational compare of one source against all slots, parameterised by eligibility mask. Instantiate twice.

Test Plan:
- FWD_EN=0: ADD rd=3 issued, next cycle src1=3 used -> stall=1 for 2 cycles (slots 0, 1), released when the producer reaches WB; hazard_src=01; stall_cnt=2.
- FWD_EN=1: LD rd=5, then ADD src2=5 -> exactly 1 stall cycle, hazard_src=10. Non-load producer rd=5 -> 0 stall cycles.
- JAL (rd=7, we=1), then JR reading r7 -> stall until the JAL leaves the eligible slots. BEQZ (we=0) followed by a reader of its rd field -> no stall.
- Hazard pending, assert flush for 1 cycle -> next cycle pipe_empty=1 and stall=0.
- drain_req=1 with 3 valid slots, pipe_en=1 -> stall=1 throughout; drain_done rises 1 cycle after the last slot empties (cycle 4); drop drain_req -> IDLE next cycle.
- pipe_en=0 with a hazard for 10 cycles -> slots held, stall=1, stall_cnt unchanged. Force stall_cnt to 16'hFFFF -> it stays 16'hFFFF. rst_n low mid-drain -> all outputs return to reset values immediately.
